// File: rtl/fft4_twiddle_sched_pkg.sv
// Shared types and defaults for the FFT4 twiddle-multiply pass scheduler.
package fft4_sched_pkg;

   localparam int LABEL_WIDTH_DEF = 11;
   localparam int PIPE_LAT_DEF    = 6;
   localparam int CREDITS_DEF     = 8;
   localparam int INFL_WIDTH_DEF  = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      FLUSH = 2'd3
   } sched_state_t;

endpackage

// File: rtl/fft4_twiddle_sched_if.sv
// Source-buffer, datapath and result-FIFO credit signals of the scheduler.
interface fft4_twiddle_sched_if
   import fft4_sched_pkg::*;
#(
   parameter int LABEL_WIDTH = LABEL_WIDTH_DEF
);
   logic                   src_valid;
   logic                   src_ack;
   logic                   dp_valid;
   logic [LABEL_WIDTH-1:0] dp_lable;
   logic                   dp_ready;
   logic [LABEL_WIDTH-1:0] dp_index;
   logic                   credit_ret;

   modport master (
      input  src_valid,
      output src_ack,
      output dp_valid,
      output dp_lable,
      input  dp_ready,
      input  dp_index,
      input  credit_ret
   );

   modport slave (
      output src_valid,
      input  src_ack,
      input  dp_valid,
      input  dp_lable,
      output dp_ready,
      output dp_index,
      output credit_ret
   );
endinterface

// File: rtl/fft4_twiddle_sched_credit.sv
// Saturating up/down counter with reload to INIT and an overflow strobe.
module fft4_sched_credit #(
   parameter int WIDTH = 4,
   parameter int INIT  = 0,
   parameter int MAX   = 15
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             inc,
   input  logic             dec,
   output logic [WIDTH-1:0] count,
   output logic             overflow
);
   localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT);
   localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX);

   logic [WIDTH-1:0] count_reg;
   logic [WIDTH-1:0] count_next;

   // Simultaneous inc and dec cancel; an inc at MAX holds and flags overflow.
   always_comb begin
      count_next = count_reg;
      overflow   = 1'b0;
      if (load) begin
         count_next = INIT_V;
      end else if (inc && !dec) begin
         if (count_reg == MAX_V) begin
            overflow = 1'b1;
         end else begin
            count_next = count_reg + 1'b1;
         end
      end else if (dec && !inc && (count_reg != '0)) begin
         count_next = count_reg - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_reg <= INIT_V;
      end else begin
         count_reg <= count_next;
      end
   end

   assign count = count_reg;

endmodule

// File: rtl/fft4_twiddle_sched.sv
// Issues labelled 4-sample groups into the fixed-latency FFT4 twiddle stage.
// Define FFT4_SCHED_ORDER_CHECK_EN to check dp_index order against issue order.
module fft4_twiddle_sched
   import fft4_sched_pkg::*;
#(
   parameter int LABEL_WIDTH = LABEL_WIDTH_DEF,
   parameter int PIPE_LAT    = PIPE_LAT_DEF,
   parameter int CREDITS     = CREDITS_DEF,
   parameter int INFL_WIDTH  = INFL_WIDTH_DEF
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   abort,
   input  logic [LABEL_WIDTH-1:0] cfg_last,
   fft4_twiddle_sched_if.master   bus,
   output logic                   busy,
   output logic                   done,
   output logic                   err
);
   localparam logic [INFL_WIDTH-1:0] FLUSH_INIT = INFL_WIDTH'(PIPE_LAT + 1);

   sched_state_t           state_reg, state_next;
   logic [LABEL_WIDTH-1:0] label_reg, label_next;
   logic [LABEL_WIDTH-1:0] last_reg, last_next;
   logic [INFL_WIDTH-1:0]  flush_cnt_reg, flush_cnt_next;
   logic                   dp_valid_reg;
   logic [LABEL_WIDTH-1:0] dp_lable_reg;
   logic                   done_reg, done_next;
   logic                   err_reg, err_next;

   logic                   issue;
   logic                   start_ok;
   logic                   err_clr;
   logic                   ready_counted;
   logic                   drained;
   logic                   flush_end;
   logic                   order_err;
   logic [INFL_WIDTH-1:0]  credits;
   logic [INFL_WIDTH-1:0]  in_flight;
   logic                   credit_ovf;
   logic                   infl_ovf;

   // Results still emerging during FLUSH belong to the aborted pass.
   assign ready_counted = bus.dp_ready && (state_reg != FLUSH);
   assign drained       = (in_flight == '0) ||
                          ((in_flight == INFL_WIDTH'(1)) && ready_counted);
   assign start_ok      = (state_reg == IDLE) && start;

   always_comb begin
      state_next     = state_reg;
      label_next     = label_reg;
      last_next      = last_reg;
      flush_cnt_next = flush_cnt_reg;
      done_next      = 1'b0;
      issue          = 1'b0;
      err_clr        = 1'b0;
      flush_end      = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start) begin
               last_next  = cfg_last;
               label_next = '0;
               err_clr    = 1'b1;
               state_next = ISSUE;
            end
         end
         ISSUE: begin
            if (abort) begin
               flush_cnt_next = FLUSH_INIT;
               state_next     = FLUSH;
            end else if (bus.src_valid && (credits != '0)) begin
               issue      = 1'b1;
               label_next = label_reg + 1'b1;
               if (label_reg == last_reg) begin
                  state_next = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (abort) begin
               flush_cnt_next = FLUSH_INIT;
               state_next     = FLUSH;
            end else if (drained) begin
               done_next  = 1'b1;
               state_next = IDLE;
            end
         end
         FLUSH: begin
            // Last FLUSH cycle is the one where the counter steps down to zero.
            if (flush_cnt_reg <= INFL_WIDTH'(1)) begin
               flush_cnt_next = '0;
               flush_end      = 1'b1;
               state_next     = IDLE;
            end else begin
               flush_cnt_next = flush_cnt_reg - 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

`ifdef FFT4_SCHED_ORDER_CHECK_EN
   logic [LABEL_WIDTH-1:0] exp_idx_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         exp_idx_reg <= '0;
      end else if (start_ok) begin
         exp_idx_reg <= '0;
      end else if (ready_counted) begin
         exp_idx_reg <= exp_idx_reg + 1'b1;
      end
   end

   assign order_err = ready_counted && (bus.dp_index != exp_idx_reg);
`else
   assign order_err = 1'b0;
`endif

   always_comb begin
      err_next = (err_reg && !err_clr) ||
                 (ready_counted && (in_flight == '0)) ||
                 credit_ovf || infl_ovf || order_err;
   end

   fft4_sched_credit #(
      .WIDTH (INFL_WIDTH),
      .INIT  (CREDITS),
      .MAX   (CREDITS)
   ) u_credits (
      .clk      (clk),
      .rst      (rst),
      .load     (flush_end),
      .inc      (bus.credit_ret),
      .dec      (issue),
      .count    (credits),
      .overflow (credit_ovf)
   );

   fft4_sched_credit #(
      .WIDTH (INFL_WIDTH),
      .INIT  (0),
      .MAX   ((1 << INFL_WIDTH) - 1)
   ) u_in_flight (
      .clk      (clk),
      .rst      (rst),
      .load     (flush_end),
      .inc      (issue),
      .dec      (ready_counted),
      .count    (in_flight),
      .overflow (infl_ovf)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= IDLE;
         label_reg     <= '0;
         last_reg      <= '0;
         flush_cnt_reg <= '0;
         dp_valid_reg  <= 1'b0;
         dp_lable_reg  <= '0;
         done_reg      <= 1'b0;
         err_reg       <= 1'b0;
      end else begin
         state_reg     <= state_next;
         label_reg     <= label_next;
         last_reg      <= last_next;
         flush_cnt_reg <= flush_cnt_next;
         dp_valid_reg  <= issue;
         if (issue) begin
            dp_lable_reg <= label_reg;
         end
         done_reg      <= done_next;
         err_reg       <= err_next;
      end
   end

   assign bus.src_ack  = issue;
   assign bus.dp_valid = dp_valid_reg;
   assign bus.dp_lable = dp_lable_reg;
   assign busy         = (state_reg != IDLE);
   assign done         = done_reg;
   assign err          = err_reg;

endmodule

// File: doc/fft4_twiddle_sched.md
Name: fft4_twiddle_sched

Overview:
- Sequences one radix-4 twiddle-multiply pass through the 6-cycle parallel FFT4 twiddle-multiply stage.
- Pulls 4-sample groups from the sample buffer via a valid/ack handshake and issues them with an incrementing 11-bit label.
- Tracks results in flight and throttles issue with credits from the downstream result FIFO, because the datapath cannot stall.
- Reports pass completion, supports abort with pipeline flush, and flags protocol errors.

Parameters:
- LABEL_WIDTH, 11, width of group label / datapath lable and index.
- PIPE_LAT, 6, datapath latency from accepted valid to ready, in clk cycles.
- CREDITS, 8, downstream result FIFO depth; initial credit count.
- INFL_WIDTH, 4, width of in-flight and credit counters; must hold max(CREDITS, PIPE_LAT+1).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  pulse; begins a pass; ignored unless in IDLE.
- abort  in  1  pulse; terminates the pass; ignored in IDLE.
- cfg_last  in  LABEL_WIDTH  last label of the pass; sampled on accepted start.
- src_valid  in  1  sample buffer has a 4-sample group ready.
- src_ack  out  1  combinational; group consumed this cycle.
- dp_valid  out  1  registered; drives datapath valid.
- dp_lable  out  LABEL_WIDTH  registered; drives datapath lable.
- dp_ready  in  1  datapath result-valid strobe.
- dp_index  in  LABEL_WIDTH  datapath result label.
- credit_ret  in  1  downstream FIFO popped one entry.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at normal pass end.
- err  out  1  sticky protocol error; cleared only by rst or accepted start.

Behaviour:
- Reset: state IDLE; src_ack=0, dp_valid=0, dp_lable=0, busy=0, done=0, err=0; label counter=0; in-flight=0; credits=CREDITS.
- States: IDLE, ISSUE, DRAIN, FLUSH.
- IDLE: start=1 latches cfg_last, clears the label counter and err, then moves to ISSUE.
- ISSUE, issue condition: src_valid && credits>0 && !abort.
  - src_ack equals the issue condition.
  - Next cycle: dp_valid=1 and dp_lable=label; otherwise dp_valid=0 and dp_lable holds.
  - On issue: label increments. If label==cfg_last, move to DRAIN with no further issue.
- In-flight counter: +1 on issue, -1 on dp_ready; both in the same cycle leaves it unchanged.
- Credits: -1 on issue, +1 on credit_ret; both in the same cycle leaves them unchanged.
  - credit_ret at credits==CREDITS saturates and sets err.
- DRAIN: when in-flight==0 (including in-flight reaching 0 this cycle), pulse done for 1 cycle and go to IDLE.
- Latency: issue at cycle t, dp_valid at t+1, expected dp_ready at t+1+PIPE_LAT.
- abort in ISSUE or DRAIN:
  - Next cycle dp_valid=0 and src_ack=0.
  - Enter FLUSH with counter=PIPE_LAT+1.
  - In FLUSH, dp_ready strobes are ignored and do not count as errors.
  - At counter 0: clear in-flight, restore credits=CREDITS, go to IDLE, no done pulse.
- abort and start in the same cycle in IDLE: start wins, abort ignored.
- err set when:
  - dp_ready arrives with in-flight==0 outside FLUSH, or
  - credit overflow as defined above.
- cfg_last=0: single group, then DRAIN.
- cfg_last=2^LABEL_WIDTH-1: label wraps to 0 after the final issue and is not reissued.
- rst asserted mid-pass: immediate return to reset values; the datapath pipeline is not flushed by this block.

Optional Feature:
- FFT4_SCHED_ORDER_CHECK_EN defined:
  - Adds an expected-index counter, advanced on each counted dp_ready.
  - dp_index != expected sets err.
  - Expected counter clears on start.
- Not defined:
  - dp_index is unused.
  - No order checking logic is synthesized.

Decomposition:
- Package fft4_sched_pkg:
  - state enum sched_state_t {IDLE, ISSUE, DRAIN, FLUSH}.
  - LABEL_WIDTH_DEF=11, PIPE_LAT_DEF=6.
- One sub-module, fft4_sched_credit: saturating up/down counter with init value, overflow flag and load; instanced for credits and for in-flight.

Test Plan:
- Normal pass:
  - Stimulus: cfg_last=7, src_valid held 1, credit_ret echoes dp_ready after 1 cycle.
  - Response: 8 issues with labels 0..7 on consecutive cycles; done pulses 1 cycle after the 8th dp_ready (t+1+6); err=0.
- Credit stall:
  - Stimulus: CREDITS=8, cfg_last=15, no credit_ret.
  - Response: exactly 8 issues then src_ack=0.
  - Follow-up: 3 credit_ret pulses give 3 more issues (labels 8,9,10).
- Source bubbles:
  - Stimulus: src_valid toggles 1,0,1,0.
  - Response: dp_valid mirrors src_ack one cycle later; labels stay contiguous; in-flight never exceeds 4.
- Abort mid-pass:
  - Stimulus: abort after label 3 issued.
  - Response: dp_valid=0 next cycle; FLUSH for 7 cycles; IDLE with credits=8; no done; stray dp_ready ignored; err=0.
- Error detection:
  - Stimulus 1: dp_ready in IDLE. Response: err=1, stays 1 until next start.
  - Stimulus 2: credit_ret at full credits. Response: err=1.
  - Stimulus 3 (macro on): dp_index=5 when 4 expected. Response: err=1.
- Async reset:
  - Stimulus: rst asserted mid-ISSUE between clock edges.
  - Response: all outputs return to reset values immediately; a new start gives labels from 0.
